// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decoder control, instruction-memory port and IF/ID register outputs.
// master = fetch stage, slave = memory/decoder side.
interface fetch_stage_if #(
  parameter int unsigned Width    = 32,
  parameter int unsigned CntWidth = 16
);
  logic                stall;
  logic                redirect_valid;
  logic [Width-1:0]    redirect_target;
  logic [Width-1:0]    imem_addr;
  logic [Width-1:0]    imem_rdata;
  logic                if_valid;
  logic [Width-1:0]    if_pc;
  logic [Width-1:0]    if_pc_plus4;
  logic [Width-1:0]    if_instr;
  logic                misalign_err;
  logic [CntWidth-1:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, misalign_err, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register: sequential advance, redirect with flush,
// decoder stall, and a wrapping fetch counter.
module fetch_stage #(
  parameter int unsigned      Width    = 32,
  parameter int unsigned      CntWidth = 16,
  parameter logic [Width-1:0] ResetPC  = '0,
  parameter logic [Width-1:0] NopInstr = Width'(32'h0000_0013)
) (
  input logic          clk,
  input logic          rst_n,
  fetch_stage_if.master bus
);

  logic [Width-1:0]    pc_q;
  logic                valid_q;
  logic [Width-1:0]    if_pc_q;
  logic [Width-1:0]    if_pc_plus4_q;
  logic [Width-1:0]    if_instr_q;
  logic                misalign_q;
  logic [CntWidth-1:0] cnt_q;

  // Redirect beats stall beats advance; the redirect target is forced word-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= ResetPC;
      valid_q       <= 1'b0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= Width'(4);
      if_instr_q    <= NopInstr;
      misalign_q    <= 1'b0;
      cnt_q         <= '0;
    end else if (bus.redirect_valid) begin
      pc_q       <= {bus.redirect_target[Width-1:2], 2'b00};
      valid_q    <= 1'b0;
      if_instr_q <= NopInstr;
      misalign_q <= |bus.redirect_target[1:0];
    end else if (bus.stall) begin
      misalign_q <= 1'b0;
    end else begin
      if_pc_q       <= pc_q;
      if_pc_plus4_q <= pc_q + Width'(4);
      if_instr_q    <= bus.imem_rdata;
      valid_q       <= 1'b1;
      pc_q          <= pc_q + Width'(4);
      cnt_q         <= cnt_q + CntWidth'(1);
      misalign_q    <= 1'b0;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.if_valid     = valid_q;
  assign bus.if_pc        = if_pc_q;
  assign bus.if_pc_plus4  = if_pc_plus4_q;
  assign bus.if_instr     = if_instr_q;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized checks of fetch_stage against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  fetch_stage_if #(.Width(32), .CntWidth(16)) bus ();

  fetch_stage #(.Width(32), .CntWidth(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Stateless memory contents: three preset words, a hash elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0020_81B3;
      32'h4:   return 32'h4032_02B3;
      32'h8:   return 32'h0030_8383;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign bus.imem_rdata = imem(bus.imem_addr);

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid, m_mis;
  logic [15:0] m_cnt;

  function automatic void model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP;
    m_valid = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
  endfunction

  function automatic void model_step(input bit s, input bit rv, input logic [31:0] rt);
    if (rv) begin
      m_pc    = rt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_instr = NOP;
      m_mis   = (rt % 4) != 0;
    end else if (s) begin
      m_mis = 1'b0;
    end else begin
      m_ifpc  = m_pc;
      m_instr = imem(m_pc);
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 16'd1;
      m_mis   = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr",    bus.imem_addr, m_pc);
    chk("if_valid",     32'(bus.if_valid), 32'(m_valid));
    chk("if_pc",        bus.if_pc, m_ifpc);
    chk("if_pc_plus4",  bus.if_pc_plus4, m_ifpc + 32'd4);
    chk("if_instr",     bus.if_instr, m_instr);
    chk("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
    chk("fetch_count",  32'(bus.fetch_count), 32'(m_cnt));
  endtask

  // Inputs are applied on the falling edge, outputs checked on the next falling edge.
  task automatic step(input bit s, input bit rv, input logic [31:0] rt);
    bus.stall           = s;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    model_step(s, rv, rt);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_addr", bus.imem_addr, 32'h0);

    // Free run from reset
    step(0, 0, 0);
    chk("c1_pc", bus.if_pc, 32'h0);
    chk("c1_instr", bus.if_instr, 32'h0020_81B3);
    chk("c1_plus4", bus.if_pc_plus4, 32'h4);
    step(0, 0, 0);
    chk("c2_instr", bus.if_instr, 32'h4032_02B3);
    step(0, 0, 0);
    chk("c3_instr", bus.if_instr, 32'h0030_8383);
    chk("c3_count", 32'(bus.fetch_count), 32'd3);

    // Stall with PC = 12
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("stall_addr", bus.imem_addr, 32'd12);
      chk("stall_pc", bus.if_pc, 32'd8);
    end
    step(0, 0, 0);
    chk("post_stall_pc", bus.if_pc, 32'd12);

    // Advance to PC = 28, then redirect to 0x40 while stalled
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("pc28", bus.imem_addr, 32'd28);
    step(1, 1, 32'h40);
    chk("redir_addr", bus.imem_addr, 32'h40);
    chk("redir_valid", 32'(bus.if_valid), 32'd0);
    chk("redir_nop", bus.if_instr, NOP);
    step(0, 0, 0);
    chk("redir_tgt_pc", bus.if_pc, 32'h40);
    chk("redir_tgt_valid", 32'(bus.if_valid), 32'd1);

    // Misaligned redirect
    step(0, 1, 32'h32);
    chk("mis_addr", bus.imem_addr, 32'h30);
    chk("mis_pulse", 32'(bus.misalign_err), 32'd1);
    step(0, 0, 0);
    chk("mis_clear", 32'(bus.misalign_err), 32'd0);
    chk("mis_fetch_pc", bus.if_pc, 32'h30);

    // Back-to-back redirects, last wins
    step(0, 1, 32'h101);
    step(0, 1, 32'h200);
    chk("b2b_mis", 32'(bus.misalign_err), 32'd0);
    chk("b2b_valid", 32'(bus.if_valid), 32'd0);
    chk("b2b_addr", bus.imem_addr, 32'h200);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus.if_pc_plus4, 32'h0);
    step(0, 0, 0);
    chk("wrap_pc0", bus.if_pc, 32'h0);
    chk("wrap_addr4", bus.imem_addr, 32'h4);

    // Asynchronous reset between edges after 5 fetches
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_count", 32'(bus.fetch_count), 32'd0);
    chk("arst_valid", 32'(bus.if_valid), 32'd0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("resume_instr", bus.if_instr, 32'h0020_81B3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [31:0] tgt;
      r   = $urandom_range(0, 99);
      tgt = (r[0]) ? $urandom : ($urandom & 32'h0000_01FF);
      step($urandom_range(0, 3) == 0, r < 15, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Program-counter and fetch stage that sits directly upstream of the instruction memory.
- Drives the byte address into the memory and captures the returned instruction word with its PC into an IF/ID register for the decoder.
- Handles sequential PC+4 advance, branch/jump redirect with flush, and decoder stall.
- Keeps a fetch counter for debug and performance.

Parameters:
- Width, 32, datapath, PC and instruction width.
- ResetPC, 0, byte address loaded into the PC on reset.
- CntWidth, 16, width of the fetch counter.
- NopInstr, 32'h00000013, instruction held in the IF/ID register when it is invalid (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  decoder cannot accept a new instruction; hold the PC and the IF/ID register.
- redirect_valid  in  1  branch taken or jump resolved this cycle.
- redirect_target  in  Width  byte address of the redirect target.
- imem_addr  out  Width  byte address to the instruction memory; equals the current PC, combinational from the PC register.
- imem_rdata  in  Width  instruction word returned by the memory in the same cycle (combinational read).
- if_valid  out  1  IF/ID register holds a real instruction.
- if_pc  out  Width  PC of the instruction in the IF/ID register.
- if_pc_plus4  out  Width  if_pc + 4, used as the link value by jal/jalr.
- if_instr  out  Width  instruction word in the IF/ID register.
- misalign_err  out  1  one-cycle pulse: the last accepted redirect target had a nonzero value in bits [1:0].
- fetch_count  out  CntWidth  number of instructions loaded into the IF/ID register since reset.

Behaviour:
- Reset, asserted asynchronously at any time including mid-stall or mid-redirect:
  - PC = ResetPC.
  - if_valid = 0, if_pc = 0, if_pc_plus4 = 4, if_instr = NopInstr.
  - misalign_err = 0, fetch_count = 0.
- Reset release: the first rising edge after rst_n rises is a normal cycle. imem_addr = ResetPC immediately after reset.
- Priority at each rising edge is redirect_valid > stall > advance.
- Redirect, when redirect_valid = 1 (stall is ignored):
  - PC <= {redirect_target[Width-1:2], 2'b00}.
  - IF/ID flushed: if_valid <= 0, if_instr <= NopInstr. if_pc and if_pc_plus4 hold.
  - misalign_err <= (redirect_target[1:0] != 0).
  - fetch_count unchanged.
- Stall, when stall = 1 and redirect_valid = 0:
  - PC, all IF/ID fields and fetch_count hold.
  - misalign_err <= 0.
- Advance, when stall = 0 and redirect_valid = 0:
  - if_pc <= PC, if_pc_plus4 <= PC + 4, if_instr <= imem_rdata, if_valid <= 1.
  - PC <= PC + 4.
  - fetch_count <= fetch_count + 1.
  - misalign_err <= 0.
- Latency: the instruction at address A appears on if_instr one cycle after imem_addr = A. After a redirect there is one bubble cycle (if_valid = 0) before the target instruction is valid.
- Arithmetic:
  - PC + 4 wraps modulo 2^Width; 32'hFFFFFFFC advances to 0 with no flag.
  - fetch_count wraps modulo 2^CntWidth.
- PC bits [1:0] are always 0. The memory is indexed by byte address with words at multiples of 4.
- misalign_err is a pure pulse: high for exactly one cycle after the redirecting edge, unless the next edge is also a misaligned redirect.
- Back-to-back redirects: each one takes effect, the last target wins, and if_valid stays 0 throughout.
- Outputs are registered except imem_addr, which is a direct copy of the PC register. There is no combinational path from any input to any output.

Test Plan:
1. Reset then free run, memory preloaded with 002081B3 @0, 403202B3 @4, 00308383 @8, stall = 0:
   - Cycle 1: if_pc = 0, if_instr = 002081B3, if_pc_plus4 = 4.
   - Cycle 2: if_pc = 4, if_instr = 403202B3.
   - Cycle 3: if_pc = 8, if_instr = 00308383.
   - fetch_count = 3.
2. Stall held for 3 cycles while the PC is 12:
   - imem_addr stays 12.
   - if_* and fetch_count are unchanged.
   - After release, the next edge loads if_pc = 12.
3. Redirect to 0x40 while the PC is 28, with stall = 1 in the same cycle:
   - Next cycle: imem_addr = 0x40, if_valid = 0, if_instr = 00000013.
   - Following cycle: if_pc = 0x40, if_valid = 1.
4. Redirect to 0x32 (misaligned):
   - PC becomes 0x30.
   - misalign_err = 1 for exactly one cycle.
   - Next fetch has if_pc = 0x30.
5. Wrap-around: redirect to 0xFFFFFFFC, then advance 2 cycles:
   - if_pc = 0xFFFFFFFC with if_pc_plus4 = 0.
   - Then if_pc = 0 and imem_addr = 4.
6. rst_n pulsed low mid-run, between clock edges, after 5 fetches:
   - Outputs take their reset values immediately without waiting for an edge.
   - imem_addr = 0, fetch_count = 0, if_valid = 0.
   - Run resumes from address 0 after release.
